// File: rtl/riscv_pkg.sv
// riscv_pkg: constants and types shared by the RV32I datapath blocks.
//   DATA_WIDTH / ADDR_WIDTH : register width and index width
//   REG_ZERO / REG_SP / REG_GP : ABI register indices with special handling
//   SP_RESET / GP_RESET     : power-on values for the stack and global pointers
//   reg_idx_t / xlen_t      : register index and register value types
package riscv_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 5;

    localparam int REG_ZERO = 0;
    localparam int REG_SP   = 2;
    localparam int REG_GP   = 3;

    localparam logic [31:0] SP_RESET = 32'h7FFF_EFFC;
    localparam logic [31:0] GP_RESET = 32'h1000_8000;

    typedef logic [4:0]  reg_idx_t;
    typedef logic [31:0] xlen_t;

endpackage

// File: rtl/register_cell.sv
// register_cell: one WIDTH-bit register with load enable and a per-instance
// reset value.
//   clk   in   rising-edge clock
//   rst_n in   asynchronous active-low reset, loads RESET_VALUE
//   i_en  in   load enable
//   i_d   in   data to load
//   o_q   out  stored value
module register_cell #(
    parameter int                WIDTH       = 32,
    parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= RESET_VALUE;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/register_file.sv
// register_file: 32 x 32-bit RV32I integer register file, two combinational
// read ports and one write port committed on the rising clock edge.
//   clk               in   core clock
//   reset             in   asynchronous active-low reset
//   Reg_Write_i       in   write enable
//   Write_Register_i  in   destination index rd
//   Write_Data_i      in   writeback value
//   Read_Register_1_i in   source index rs1
//   Read_Register_2_i in   source index rs2
//   Read_Data_1_o     out  contents of rs1 (ALU operand A)
//   Read_Data_2_o     out  contents of rs2 (ALU operand B / store data)
// x0 has no storage and always reads zero. Reads deliberately have no
// write-through bypass: in the single-cycle datapath the read data feeds the
// ALU which feeds Write_Data_i, so a bypass would close a combinational loop.
module register_file #(
    parameter int                      DATA_WIDTH = riscv_pkg::DATA_WIDTH,
    parameter int                      ADDR_WIDTH = riscv_pkg::ADDR_WIDTH,
    parameter logic [DATA_WIDTH-1:0]   SP_RESET   = riscv_pkg::SP_RESET,
    parameter logic [DATA_WIDTH-1:0]   GP_RESET   = riscv_pkg::GP_RESET
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Reg_Write_i,
    input  logic [ADDR_WIDTH-1:0] Write_Register_i,
    input  logic [DATA_WIDTH-1:0] Write_Data_i,
    input  logic [ADDR_WIDTH-1:0] Read_Register_1_i,
    input  logic [ADDR_WIDTH-1:0] Read_Register_2_i,
    output logic [DATA_WIDTH-1:0] Read_Data_1_o,
    output logic [DATA_WIDTH-1:0] Read_Data_2_o
);

    import riscv_pkg::REG_ZERO, riscv_pkg::REG_SP, riscv_pkg::REG_GP;

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] w_regs [NUM_REGS];
    logic [NUM_REGS-1:1]   w_wr_en;

    // Index 0 has no cell; the constant keeps the read mux uniform.
    assign w_regs[REG_ZERO] = '0;

    genvar k;
    generate
        for (k = 1; k < NUM_REGS; k++) begin : g_reg
            localparam logic [DATA_WIDTH-1:0] RV =
                (k == REG_SP) ? SP_RESET :
                (k == REG_GP) ? GP_RESET : '0;

            // One-hot write decode; k never equals 0, so x0 writes vanish here.
            assign w_wr_en[k] = Reg_Write_i && (Write_Register_i == ADDR_WIDTH'(k));

            register_cell #(
                .WIDTH       (DATA_WIDTH),
                .RESET_VALUE (RV)
            ) u_cell (
                .clk   (clk),
                .rst_n (reset),
                .i_en  (w_wr_en[k]),
                .i_d   (Write_Data_i),
                .o_q   (w_regs[k])
            );
        end
    endgenerate

    assign Read_Data_1_o = (Read_Register_1_i == ADDR_WIDTH'(REG_ZERO)) ? '0
                                                                        : w_regs[Read_Register_1_i];
    assign Read_Data_2_o = (Read_Register_2_i == ADDR_WIDTH'(REG_ZERO)) ? '0
                                                                        : w_regs[Read_Register_2_i];

endmodule

// File: tb/tb_register_file.sv
`timescale 1ns/1ps
module tb_register_file;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        we = 1'b0;
    logic [4:0]  wr = '0;
    logic [31:0] wd = '0;
    logic [4:0]  rs1 = '0;
    logic [4:0]  rs2 = '0;
    logic [31:0] rd1, rd2;

    always #5 clk = ~clk;

    register_file dut (
        .clk               (clk),
        .reset             (reset),
        .Reg_Write_i       (we),
        .Write_Register_i  (wr),
        .Write_Data_i      (wd),
        .Read_Register_1_i (rs1),
        .Read_Register_2_i (rs2),
        .Read_Data_1_o     (rd1),
        .Read_Data_2_o     (rd2)
    );

    // ---------------- behavioural model ----------------
    // Architectural register contents as a plain array.
    logic [31:0] m [32];

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) m[i] <= 32'h0;
            m[2] <= 32'h7FFF_EFFC;
            m[3] <= 32'h1000_8000;
        end else if (we && wr != 5'd0) begin
            m[wr] <= wd;
        end
    end

    function automatic logic [31:0] model_read(input logic [4:0] idx);
        return (idx == 5'd0) ? 32'h0 : m[idx];
    endfunction

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Per-cycle compare against the model, sampled away from the active edge.
    logic check_en = 1'b0;
    always @(negedge clk) begin
        if (check_en) begin
            exp_q.push_back(model_read(rs1));
            exp_q.push_back(model_read(rs2));
            check("model_rd1", rd1, exp_q.pop_front());
            check("model_rd2", rd2, exp_q.pop_front());
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_write(input logic [4:0] rd, input logic [31:0] d);
        @(negedge clk); #1;
        we = 1'b1; wr = rd; wd = d;
        @(posedge clk); #1;
        we = 1'b0;
    endtask

    task automatic read_pair(input logic [4:0] a, input logic [4:0] b);
        rs1 = a; rs2 = b; #0.05;
    endtask

    logic [31:0] exp_v;

    initial begin
        // 1. reset mid-cycle, all indices readable before any clock edge
        #2 reset = 1'b0;
        for (int i = 0; i < 32; i++) begin
            read_pair(5'(i), 5'(31 - i));
            exp_v = (i == 2) ? 32'h7FFF_EFFC : (i == 3) ? 32'h1000_8000 : 32'h0;
            check("reset_rd1", rd1, exp_v);
            exp_v = ((31 - i) == 2) ? 32'h7FFF_EFFC : ((31 - i) == 3) ? 32'h1000_8000 : 32'h0;
            check("reset_rd2", rd2, exp_v);
        end
        @(negedge clk); #1 reset = 1'b1;

        // 2. write/read
        do_write(5'd5, 32'hDEAD_BEEF);
        read_pair(5'd5, 5'd5);
        check("wr5_rd1", rd1, 32'hDEAD_BEEF);
        check("wr5_rd2", rd2, 32'hDEAD_BEEF);
        read_pair(5'd4, 5'd6);
        check("x4_zero", rd1, 32'h0);
        check("x6_zero", rd2, 32'h0);

        // 3. x0 protection
        do_write(5'd0, 32'hFFFF_FFFF);
        read_pair(5'd0, 5'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("x0_rd1", rd1, 32'h0);
            check("x0_rd2", rd2, 32'h0);
        end

        // 4. enable low
        do_write(5'd7, 32'h1234_5678);
        @(negedge clk); #1 we = 1'b0; wr = 5'd7; wd = 32'h0;
        repeat (3) @(posedge clk);
        #1 read_pair(5'd7, 5'd7);
        check("x7_hold", rd1, 32'h1234_5678);

        // 5. read-during-write: old value until the edge, new after
        do_write(5'd9, 32'h0000_0001);
        @(negedge clk); #1;
        rs1 = 5'd9; we = 1'b1; wr = 5'd9; wd = 32'h0000_0002;
        #0.5 check("rdw_before_a", rd1, 32'h0000_0001);
        #3.0 check("rdw_before_b", rd1, 32'h0000_0001);
        @(posedge clk); #1;
        check("rdw_after", rd1, 32'h0000_0002);
        we = 1'b0;

        // 6. reset mid-operation, write during reset is lost
        do_write(5'd2, 32'h0);
        do_write(5'd10, 32'hAAAA_AAAA);
        read_pair(5'd2, 5'd10);
        check("pre_rst_x2", rd1, 32'h0);
        check("pre_rst_x10", rd2, 32'hAAAA_AAAA);
        @(negedge clk); #1 reset = 1'b0;
        #0.5 check("rst_x2", rd1, 32'h7FFF_EFFC);
        check("rst_x10", rd2, 32'h0);
        we = 1'b1; wr = 5'd11; wd = 32'h5555_5555;
        @(posedge clk); #1;
        // first edge after release must take the write
        @(negedge clk); #1 reset = 1'b1; wr = 5'd12; wd = 32'h00C0_FFEE;
        @(posedge clk); #1 we = 1'b0;
        read_pair(5'd11, 5'd12);
        check("rst_write_lost", rd1, 32'h0);
        check("first_write_after_rst", rd2, 32'h00C0_FFEE);

        // Randomised phase against the model; the model is reset here too.
        @(negedge clk); #1 reset = 1'b0;
        @(negedge clk); #1 reset = 1'b1;
        check_en = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk); #1;
            we  = ($urandom_range(0, 3) != 0);
            wr  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            wd  = $urandom;
            rs1 = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
            rs2 = ($urandom_range(0, 3) == 0) ? rs1 : 5'($urandom_range(0, 31));
            if ($urandom_range(0, 99) == 0) reset = 1'b0;
            else reset = 1'b1;
        end
        @(negedge clk); #1 reset = 1'b1; we = 1'b0;
        @(negedge clk);
        check_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
